// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator-CPU control sequencer.
//   - opcode constants decoded from G[14:12]
//   - sequencer state encoding (3 bits)
//   - run-mode constants
package acc_pkg;

   localparam logic [2:0] OP_HALT = 3'b000;
   localparam logic [2:0] OP_TCF  = 3'b001;
   localparam logic [2:0] OP_CA   = 3'b011;
   localparam logic [2:0] OP_AD   = 3'b110;

   localparam logic MANUAL_MODE    = 1'b1;
   localparam logic AUTOMATIC_MODE = 1'b0;

   typedef enum logic [2:0] {
      WAIT    = 3'd0,
      FETCH   = 3'd1,
      READ_OP = 3'd2,
      EXEC0   = 3'd3,
      EXEC1   = 3'd4,
      HALT    = 3'd5
   } state_t;

   // Instructions that take a direct memory operand and need EXEC1.
   function automatic logic is_mem_op(input logic [2:0] op);
      return (op == OP_CA) || (op == OP_AD);
   endfunction

endpackage

// File: rtl/acc_trig_sel.sv
// acc_trig_sel: run-mode flip-flop and trigger selection.
//   clk, rst      : clock, synchronous active-high reset
//   step          : manual-mode advance pulse
//   tick          : automatic-mode advance pulse
//   toggle        : flips the mode
//   mode          : registered mode (1 = manual, 0 = automatic)
//   event_trig    : step or tick, chosen by the registered mode
module acc_trig_sel
   import acc_pkg::*;
#(
   parameter bit DEFAULT_MODE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic step,
   input  logic tick,
   input  logic toggle,
   output logic mode,
   output logic event_trig
);

   always_ff @(posedge clk) begin
      if (rst) begin
         mode <= DEFAULT_MODE;
      end else if (toggle) begin
         mode <= ~mode;
      end
   end

   // Uses the registered mode, so a toggle arriving together with a trigger
   // still qualifies that trigger with the old mode.
   assign event_trig = (mode == MANUAL_MODE) ? step : tick;

endmodule

// File: rtl/acc_seq.sv
// acc_seq: control sequencer for the accumulator-CPU datapath.
//   clk, rst   : clock, synchronous active-high reset (wins over all inputs)
//   step, tick : one-cycle advance pulses (manual / automatic mode)
//   toggle     : one-cycle pulse flipping the run mode
//   opcode     : G[14:12], sampled only in EXEC0/EXEC1
//   wg, incs, ws, addr_sel, wa, alu_add : datapath strobes
//   mode       : current run mode
//   halted     : core sits in HALT until reset
//   instr_done : pulse in the last execution cycle of every instruction
//   icount     : retired-instruction counter, wraps silently
//   state_dbg  : current sequencer state
//
// Interface semantics: step, tick and toggle are single-cycle events with no
// back-pressure. A trigger is consumed only in WAIT; anywhere else it is
// dropped, never queued. Strobes are one cycle wide except addr_sel, which
// holds through both memory-operand cycles.
module acc_seq
   import acc_pkg::*;
#(
   parameter bit DEFAULT_MODE = 1'b1,
   parameter int CW           = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic          tick,
   input  logic          toggle,
   input  logic [2:0]    opcode,
   output logic          wg,
   output logic          incs,
   output logic          ws,
   output logic          addr_sel,
   output logic          wa,
   output logic          alu_add,
   output logic          mode,
   output logic          halted,
   output logic          instr_done,
   output logic [CW-1:0] icount,
   output logic [2:0]    state_dbg
);

   state_t state;
   logic   event_trig;

   acc_trig_sel #(
      .DEFAULT_MODE (DEFAULT_MODE)
   ) u_trig_sel (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .tick       (tick),
      .toggle     (toggle),
      .mode       (mode),
      .event_trig (event_trig)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= WAIT;
         icount <= '0;
      end else begin
         if (instr_done) begin
            icount <= icount + CW'(1);
         end
         case (state)
            WAIT:    if (event_trig) state <= FETCH;
            FETCH:   state <= READ_OP;
            READ_OP: state <= EXEC0;
            EXEC0: begin
               if (opcode == OP_HALT)     state <= HALT;
               else if (is_mem_op(opcode)) state <= EXEC1;
               else                        state <= WAIT;
            end
            EXEC1:   state <= WAIT;
            HALT:    state <= HALT;
            default: state <= WAIT;
         endcase
      end
   end

   // Strobes decode straight from the registered state and opcode; FETCH
   // relies on addr_sel = 0 so the ROM reads mem[S] on the falling edge.
   always_comb begin
      wg         = 1'b0;
      incs       = 1'b0;
      ws         = 1'b0;
      addr_sel   = 1'b0;
      wa         = 1'b0;
      alu_add    = 1'b0;
      instr_done = 1'b0;
      case (state)
         READ_OP: begin
            wg   = 1'b1;
            incs = 1'b1;
         end
         EXEC0: begin
            if (opcode == OP_TCF) begin
               ws         = 1'b1;
               instr_done = 1'b1;
            end else if (is_mem_op(opcode)) begin
               addr_sel = 1'b1;
            end else begin
               instr_done = 1'b1;
            end
         end
         EXEC1: begin
            addr_sel   = 1'b1;
            wa         = 1'b1;
            alu_add    = (opcode == OP_AD);
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign halted    = (state == HALT);
   assign state_dbg = state;

endmodule

// File: tb/tb_acc_seq.sv
module tb_acc_seq;
   import acc_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          step = 1'b0;
   logic          tick = 1'b0;
   logic          toggle = 1'b0;
   logic [2:0]    opcode = 3'b000;
   logic          wg, incs, ws, addr_sel, wa, alu_add;
   logic          mode, halted, instr_done;
   logic [CW-1:0] icount;
   logic [2:0]    state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [CW-1:0] exp_icount = '0;

   acc_seq #(.DEFAULT_MODE(1'b1), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .tick       (tick),
      .toggle     (toggle),
      .opcode     (opcode),
      .wg         (wg),
      .incs       (incs),
      .ws         (ws),
      .addr_sel   (addr_sel),
      .wa         (wa),
      .alu_add    (alu_add),
      .mode       (mode),
      .halted     (halted),
      .instr_done (instr_done),
      .icount     (icount),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // {wg, incs, ws, addr_sel, wa, alu_add, instr_done, halted}
   function automatic logic [7:0] strobes();
      return {wg, incs, ws, addr_sel, wa, alu_add, instr_done, halted};
   endfunction

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] e1, e2, e3, e4;
   } vec_t;

   vec_t vecs[7];

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   // kind: 0 = step, 1 = tick, 2 = step with toggle
   task automatic pulse(input int kind);
      @(posedge clk); #1;
      step   = (kind == 0 || kind == 2);
      tick   = (kind == 1);
      toggle = (kind == 2);
      @(posedge clk); #1;
      step = 1'b0; tick = 1'b0; toggle = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_icount = '0;
   endtask

   // Triggers one instruction and checks the four cycles after the trigger
   // edge, then the settled state and counter.
   task automatic run_instr(input vec_t v, input int kind, input logic [2:0] end_state);
      logic [7:0] e[4];
      e[0] = v.e1; e[1] = v.e2; e[2] = v.e3; e[3] = v.e4;
      opcode = v.op;
      pulse(kind);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("%s_cyc%0d", v.name, c + 1), 32'(strobes()), 32'(e[c]));
      end
      exp_icount = exp_icount + CW'(1);
      @(negedge clk);
      check({v.name, "_state"}, 32'(state_dbg), 32'(end_state));
      check({v.name, "_icount"}, 32'(icount), 32'(exp_icount));
   endtask

   task automatic expect_idle(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         check({name, "_strobes"}, 32'(strobes()), 32'h0);
         check({name, "_state"}, 32'(state_dbg), 32'(WAIT));
      end
   endtask

   initial begin
      vec_t nop;
      vecs[0] = '{"tcf",   3'b001, 8'h00, 8'hC0, 8'h22, 8'h00};
      vecs[1] = '{"ad",    3'b110, 8'h00, 8'hC0, 8'h10, 8'h1E};
      vecs[2] = '{"ca",    3'b011, 8'h00, 8'hC0, 8'h10, 8'h1A};
      vecs[3] = '{"nop2",  3'b010, 8'h00, 8'hC0, 8'h02, 8'h00};
      vecs[4] = '{"nop4",  3'b100, 8'h00, 8'hC0, 8'h02, 8'h00};
      vecs[5] = '{"nop5",  3'b101, 8'h00, 8'hC0, 8'h02, 8'h00};
      vecs[6] = '{"nop7",  3'b111, 8'h00, 8'hC0, 8'h02, 8'h00};
      nop = vecs[3];

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_strobes", 32'(strobes()), 32'h0);
      check("rst_state",   32'(state_dbg), 32'(WAIT));
      check("rst_mode",    32'(mode),      32'd1);
      check("rst_icount",  32'(icount),    32'd0);

      // Ticks are ignored in manual mode
      opcode = 3'b001;
      for (int i = 0; i < 5; i++) begin
         pulse(1);
         expect_idle("tick_in_manual", 1);
      end

      // Table-driven single instructions in manual mode
      foreach (vecs[i]) run_instr(vecs[i], 0, WAIT);

      // Toggle together with step: old (manual) mode qualifies the step
      run_instr(vecs[0], 2, WAIT);
      check("mode_after_toggle", 32'(mode), 32'd0);
      pulse(0);
      expect_idle("step_in_auto", 3);
      run_instr(nop, 1, WAIT);
      run_instr(vecs[1], 1, WAIT);
      pulse(3);
      toggle = 1'b0;
      @(posedge clk); #1 toggle = 1'b1;
      @(posedge clk); #1 toggle = 1'b0;
      @(negedge clk);
      check("mode_back_manual", 32'(mode), 32'd1);

      // HALT: sticky until reset, mode still toggles
      opcode = 3'b000;
      begin
         vec_t h;
         h = '{"halt", 3'b000, 8'h00, 8'hC0, 8'h02, 8'h01};
         run_instr(h, 0, HALT);
      end
      check("halt_flag", 32'(halted), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 step = 1'b1; tick = 1'b1;
         @(posedge clk); #1 step = 1'b0; tick = 1'b0;
         @(negedge clk);
         check("halt_hold_strobes", 32'(strobes()), 32'h01);
         check("halt_hold_icount",  32'(icount),    32'(exp_icount));
      end
      @(posedge clk); #1 toggle = 1'b1;
      @(posedge clk); #1 toggle = 1'b0;
      @(negedge clk);
      check("halt_toggle_mode", 32'(mode), 32'd0);
      check("halt_toggle_state", 32'(state_dbg), 32'(HALT));
      do_reset();
      @(negedge clk);
      check("halt_rst_halted", 32'(halted),    32'd0);
      check("halt_rst_state",  32'(state_dbg), 32'(WAIT));
      check("halt_rst_icount", 32'(icount),    32'd0);
      check("halt_rst_mode",   32'(mode),      32'd1);

      // Counter wrap with CW = 4: 15 -> 0 -> 1
      for (int i = 1; i <= 17; i++) begin
         run_instr(nop, 0, WAIT);
         if (i == 15) check("wrap_15", 32'(icount), 32'd15);
         if (i == 16) check("wrap_16", 32'(icount), 32'd0);
         if (i == 17) check("wrap_17", 32'(icount), 32'd1);
      end

      // Reset during EXEC0 of CA abandons it with no wa pulse
      opcode = 3'b011;
      pulse(0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ca_exec0_state", 32'(state_dbg), 32'(EXEC0));
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_icount = '0;
      @(negedge clk);
      check("midrst_strobes", 32'(strobes()), 32'h0);
      check("midrst_state",   32'(state_dbg), 32'(WAIT));
      check("midrst_icount",  32'(icount),    32'(exp_icount));

      // Step during EXEC1 is dropped
      pulse(0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ca_exec1_strobes", 32'(strobes()), 32'h1A);
      step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      exp_icount = exp_icount + CW'(1);
      check("exec1_step_icount", 32'(icount), 32'(exp_icount));
      expect_idle("exec1_step_dropped", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/acc_seq.md
Name: acc_seq

Overview:
- Control sequencer for the accumulator-CPU datapath: S address register, G instruction register, 2K ROM read on clk falling edge, and a new A accumulator.
- Replaces the inline control FSM.
- Owns run-mode control: manual single-step or automatic timer-driven.
- Decodes the 3-bit opcode into one-cycle datapath strobes and adds multi-cycle memory-operand instructions, a halt, and an instruction counter.

Parameters:
- DEFAULT_MODE, 1, mode after reset (1 = manual, 0 = automatic).
- CW, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- step  in  1  debounced one-cycle pulse; advances one instruction in manual mode.
- tick  in  1  one-cycle timer pulse; advances one instruction in automatic mode.
- toggle  in  1  one-cycle pulse; flips the mode.
- opcode  in  3  G[14:12], valid from the cycle after wg.
- wg  out  1  load G from ROM data.
- incs  out  1  S <= S+1.
- ws  out  1  S <= G[11:0].
- addr_sel  out  1  ROM address mux select: 0 = S, 1 = G[11:0].
- wa  out  1  load A from the ALU result.
- alu_add  out  1  ALU op: 0 = pass ROM data, 1 = A + ROM data (16-bit, carry dropped).
- mode  out  1  current mode (drives the debug LED).
- halted  out  1  the core is in HALT.
- instr_done  out  1  one-cycle pulse in the last execution cycle of every instruction.
- icount  out  CW  count of retired instructions.

Behaviour:
- Reset (rst high at a posedge):
  - state = WAIT, mode = DEFAULT_MODE, icount = 0.
  - All strobes, halted and instr_done = 0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-instruction abandons the instruction; no strobe is asserted in the following cycle.
- Strobes are combinational from the registered state and opcode. Each strobe lasts exactly one cycle per instruction, except addr_sel, which holds for two cycles.
- Opcodes:
  - 000 HALT.
  - 001 TCF: unconditional jump.
  - 011 CA: A <= mem[dir12].
  - 110 AD: A <= A + mem[dir12].
  - All others are NOPs.
- States and transitions:
  - WAIT: no strobes.
    - Manual mode: go to FETCH when step = 1; ignore tick.
    - Automatic mode: go to FETCH when tick = 1; ignore step.
  - FETCH: addr_sel = 0; ROM reads mem[S] on the falling edge. Next state is READ_OP.
  - READ_OP: wg = 1, incs = 1. Next state is EXEC0.
  - EXEC0: action depends on opcode.
    - TCF: ws = 1, instr_done = 1, then WAIT.
    - CA or AD: addr_sel = 1, then EXEC1.
    - HALT: instr_done = 1, then HALT.
    - Other (NOP): instr_done = 1, then WAIT.
  - EXEC1: addr_sel = 1, wa = 1, alu_add = 1 when opcode = AD, instr_done = 1. Next state is WAIT.
  - HALT: halted = 1, no strobes. Step, tick and toggle do not leave HALT; only rst does. The mode still toggles while in HALT.
- Latency, counted in cycles from the trigger posedge to instr_done:
  - TCF, NOP, HALT: instr_done is asserted in the 3rd cycle after the trigger.
  - CA, AD: instr_done is asserted in the 4th cycle after the trigger.
- Triggers outside WAIT are dropped, not queued. A step pulse during EXEC0 has no effect.
- Mode:
  - mode <= ~mode on toggle, in any state.
  - When toggle and step/tick arrive in the same cycle, the trigger is qualified with the old (registered) mode.
- icount:
  - Increments on every instr_done, HALT included.
  - Wraps from 2^CW-1 to 0 with no flag.
- opcode is sampled only in EXEC0 and EXEC1. It must be stable there, which holds because G changes only on wg.

Decomposition:
- Shared package acc_pkg:
  - Opcode constants OP_HALT, OP_TCF, OP_CA, OP_AD.
  - State encoding WAIT, FETCH, READ_OP, EXEC0, EXEC1, HALT (3 bits).
  - Mode constants MANUAL_MODE = 1, AUTOMATIC_MODE = 0.
- One sub-module, acc_trig_sel: the registered mode flip-flop plus the step/tick mux, with output event_trig.
- The FSM and the counter stay in acc_seq.

Test Plan:
1. Reset with DEFAULT_MODE = 1; pulse tick 5 times, then step once with opcode = 001 -> no activity while tick pulses; after step: wg/incs in cycle 2, ws and instr_done in cycle 3; icount = 1; then WAIT.
2. Step with opcode = 110 -> addr_sel high in EXEC0 and EXEC1; wa = 1 and alu_add = 1 only in EXEC1; instr_done in cycle 4. Repeat with 011 -> alu_add = 0.
3. Toggle and step in the same cycle from manual mode -> the instruction starts (old mode was manual) and mode = 0 afterward. Later step pulses are ignored, and each tick starts one instruction.
4. Opcode 000 -> halted = 1 after EXEC0. 10 step and tick pulses -> no strobes, icount unchanged. Then rst -> halted = 0, state WAIT, icount = 0.
5. CW = 4: run 17 NOP instructions (opcode 010) -> icount reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
6. Assert rst during EXEC0 of a CA instruction, and separately step during EXEC1 -> after rst there is no wa pulse and the state is WAIT; the step during EXEC1 is dropped (no new FETCH).
